// File: rtl/pat_sched_pkg.sv
// rtl/pat_sched_pkg.sv - shared types and default sizes for the pattern evaluation scheduler
//
// Purpose: state encoding and default datapath sizing shared by pattern_eval_sched
//          and its tests.
// Ports:   none (package).
package pat_sched_pkg;

  localparam int PAT_IN_W   = 15;
  localparam int PAT_OUT_W  = 12;
  localparam int PAT_DP_LAT = 2;

  // Wait counter must hold the largest legal latency (15).
  localparam int PAT_CNT_W  = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    WAIT = S_WAIT,
    RESP = S_RESP
  } pat_state_e;

endpackage

// File: rtl/pat_rr_arb2.sv
// rtl/pat_rr_arb2.sv - two-way round-robin grant
//
// Purpose: picks one of two requesters; on contention the one not granted
//          last wins.
// Ports:
//   valid0, valid1 : request lines
//   last_gnt       : id of the requester granted most recently
//   gnt[1:0]       : one-hot grant, bit N for requester N (zero when idle)
module pat_rr_arb2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (valid0 && valid1) begin
      gnt = last_gnt ? 2'b01 : 2'b10;
    end else if (valid0) begin
      gnt = 2'b01;
    end else if (valid1) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/pattern_eval_sched.sv
// rtl/pattern_eval_sched.sv - schedules two requesters onto one fixed-latency pattern datapath
//
// Purpose: accepts a vector from one of two requesters, drives it to the shared
//          datapath, captures the result DP_LAT cycles later and presents it
//          until the consumer takes it.
// Ports:
//   blif_clk_net, blif_reset_net : clock, async active-low reset
//   reqN_valid/reqN_data/reqN_ready : requester N handshake (ready is combinational)
//   dp_in / dp_out               : shared datapath input (registered) and result
//   rsp_valid/rsp_id/rsp_data/rsp_ready : response handshake
//   busy                         : FSM not idle
//   gnt_cnt0, gnt_cnt1           : per-requester accept counters, only with
//                                  PAT_SCHED_PERF_EN defined
module pattern_eval_sched
  import pat_sched_pkg::*;
#(
  parameter int IN_W   = PAT_IN_W,
  parameter int OUT_W  = PAT_OUT_W,
  parameter int DP_LAT = PAT_DP_LAT
) (
  input  logic             blif_clk_net,
  input  logic             blif_reset_net,
  input  logic             req0_valid,
  input  logic [IN_W-1:0]  req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [IN_W-1:0]  req1_data,
  output logic             req1_ready,
  output logic [IN_W-1:0]  dp_in,
  input  logic [OUT_W-1:0] dp_out,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [OUT_W-1:0] rsp_data,
  input  logic             rsp_ready,
  output logic             busy
`ifdef PAT_SCHED_PERF_EN
  ,
  output logic [15:0]      gnt_cnt0,
  output logic [15:0]      gnt_cnt1
`endif
);

  logic [1:0]           state;
  logic [PAT_CNT_W-1:0] wait_cnt;
  logic                 last_gnt;
  logic [1:0]           gnt;
  logic                 in_idle;
  logic                 accept;

  pat_rr_arb2 u_arb (
    .valid0   (req0_valid),
    .valid1   (req1_valid),
    .last_gnt (last_gnt),
    .gnt      (gnt)
  );

  assign in_idle    = (state == S_IDLE);
  assign req0_ready = in_idle && gnt[0];
  assign req1_ready = in_idle && gnt[1];
  assign accept     = req0_ready || req1_ready;
  assign rsp_valid  = (state == S_RESP);
  assign busy       = !in_idle;

  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      state    <= S_IDLE;
      dp_in    <= '0;
      rsp_data <= '0;
      rsp_id   <= 1'b0;
      wait_cnt <= '0;
      last_gnt <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            dp_in    <= gnt[1] ? req1_data : req0_data;
            rsp_id   <= gnt[1];
            last_gnt <= gnt[1];
            wait_cnt <= PAT_CNT_W'(DP_LAT);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 1'b1;
          // dp_in has been stable for DP_LAT cycles when the count reaches 1.
          if (wait_cnt == PAT_CNT_W'(1)) begin
            rsp_data <= dp_out;
            state    <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PAT_SCHED_PERF_EN
  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      gnt_cnt0 <= 16'd0;
      gnt_cnt1 <= 16'd0;
    end else begin
      if (req0_ready) gnt_cnt0 <= gnt_cnt0 + 16'd1;
      if (req1_ready) gnt_cnt1 <= gnt_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pattern_eval_sched.sv
// tb/tb_pattern_eval_sched.sv - directed self-checking bench for pattern_eval_sched
module tb_pattern_eval_sched;

  localparam int IN_W   = 15;
  localparam int OUT_W  = 12;
  localparam int DP_LAT = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic [IN_W-1:0]  req0_data, req1_data;
  logic             req0_ready, req1_ready;
  logic [IN_W-1:0]  dp_in;
  logic [OUT_W-1:0] dp_out;
  logic             rsp_valid, rsp_id, rsp_ready, busy;
  logic [OUT_W-1:0] rsp_data;
`ifdef PAT_SCHED_PERF_EN
  logic [15:0]      gnt_cnt0, gnt_cnt1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pattern_eval_sched #(.IN_W(IN_W), .OUT_W(OUT_W), .DP_LAT(DP_LAT)) dut (
    .blif_clk_net   (clk),
    .blif_reset_net (rst_n),
    .req0_valid     (req0_valid),
    .req0_data      (req0_data),
    .req0_ready     (req0_ready),
    .req1_valid     (req1_valid),
    .req1_data      (req1_data),
    .req1_ready     (req1_ready),
    .dp_in          (dp_in),
    .dp_out         (dp_out),
    .rsp_valid      (rsp_valid),
    .rsp_id         (rsp_id),
    .rsp_data       (rsp_data),
    .rsp_ready      (rsp_ready),
    .busy           (busy)
`ifdef PAT_SCHED_PERF_EN
    ,
    .gnt_cnt0       (gnt_cnt0),
    .gnt_cnt1       (gnt_cnt1)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every cycle of activity starts 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = '0;
    req1_data  = '0;
    dp_out     = '0;
    rsp_ready  = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_rsp();
    bit found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check_eq("rsp_timeout", found, 1);
  endtask

  task automatic txn(input bit id);
    bit got = 1'b0;
    if (id) req1_valid = 1'b1; else req0_valid = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (id ? req1_ready : req0_ready) begin
        got = 1'b1;
        break;
      end
      step();
    end
    check_eq("txn_ready_timeout", got, 1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    wait_rsp();
    check_eq("txn_rsp_id", rsp_id, id);
    step();
  endtask

  int acc_id [4];
  int acc_cyc[4];
  int n_acc;
  int exp_q[$];
  bit prev_acc;
  int prev_id;
  int vcount;
  logic [OUT_W-1:0] hold_data;
  logic             hold_id;

  initial begin
    // Reset state and single-request latency
    do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_dp_in", dp_in, 0);
    check_eq("rst_rsp_data", rsp_data, 0);
    check_eq("rst_rsp_id", rsp_id, 0);
    rst_n = 1'b1;
    step();

    req0_valid = 1'b1;
    req0_data  = 15'h1234;
    dp_out     = 12'hABC;
    #1;
    check_eq("t0_req0_ready", req0_ready, 1);
    check_eq("t0_req1_ready", req1_ready, 0);
    step();
    req0_valid = 1'b0;
    #1;
    check_eq("t1_dp_in", dp_in, 15'h1234);
    check_eq("t1_busy", busy, 1);
    check_eq("t1_rsp_valid", rsp_valid, 0);
    for (int k = 2; k <= DP_LAT; k++) begin
      step();
      check_eq("wait_rsp_valid", rsp_valid, 0);
    end
    step();
    check_eq("lat_rsp_valid", rsp_valid, 1);
    check_eq("lat_rsp_id", rsp_id, 0);
    check_eq("lat_rsp_data", rsp_data, 12'hABC);

    // Back-pressure: response held, no new accepts, datapath output ignored
    hold_data  = rsp_data;
    hold_id    = rsp_id;
    dp_out     = 12'h555;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check_eq("hold_rsp_valid", rsp_valid, 1);
      check_eq("hold_rsp_id", rsp_id, hold_id);
      check_eq("hold_rsp_data", rsp_data, hold_data);
      check_eq("hold_req0_ready", req0_ready, 0);
      check_eq("hold_req1_ready", req1_ready, 0);
      check_eq("hold_busy", busy, 1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    step();
    check_eq("release_busy", busy, 0);
    check_eq("release_rsp_valid", rsp_valid, 0);
    // Withdrawn requests leave nothing behind
    step();
    step();
    check_eq("idle_busy", busy, 0);

    // Round robin under continuous contention
    do_reset();
    step();
    req0_data  = 15'h0111;
    req1_data  = 15'h0222;
    dp_out     = 12'h3C3;
    rsp_ready  = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    n_acc      = 0;
    prev_acc   = 1'b0;
    prev_id    = 0;
    for (int c = 0; c < 4 * (DP_LAT + 2) + 2; c++) begin
      #1;
      if (prev_acc) check_eq("rr_dp_in", dp_in, prev_id ? 15'h0222 : 15'h0111);
      if (rsp_valid && exp_q.size() > 0) begin
        check_eq("rr_rsp_id", rsp_id, exp_q.pop_front());
        check_eq("rr_rsp_data", rsp_data, 12'h3C3);
      end
      prev_acc = req0_ready || req1_ready;
      prev_id  = req1_ready ? 1 : 0;
      if (prev_acc && n_acc < 4) begin
        acc_id[n_acc]  = prev_id;
        acc_cyc[n_acc] = c;
        exp_q.push_back(prev_id);
        n_acc++;
      end
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_eq("rr_accepts", n_acc, 4);
    for (int i = 0; i < n_acc; i++) begin
      check_eq("rr_grant_order", acc_id[i], i % 2);
      if (i > 0) check_eq("rr_spacing", acc_cyc[i] - acc_cyc[i-1], DP_LAT + 2);
    end

    // Reset while waiting on the datapath
    do_reset();
    step();
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    check_eq("midrst_busy_before", busy, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_rsp_valid", rsp_valid, 0);
    check_eq("midrst_dp_in", dp_in, 0);
    step();
    rst_n  = 1'b1;
    vcount = 0;
    for (int k = 0; k < DP_LAT + 4; k++) begin
      step();
      if (rsp_valid) vcount++;
    end
    check_eq("midrst_no_rsp", vcount, 0);

    // Lone requester 1 is granted
    req1_valid = 1'b1;
    req1_data  = 15'h7FFF;
    dp_out     = 12'hFFF;
    #1;
    check_eq("solo1_req1_ready", req1_ready, 1);
    check_eq("solo1_req0_ready", req0_ready, 0);
    step();
    req1_valid = 1'b0;
    check_eq("solo1_dp_in", dp_in, 15'h7FFF);
    wait_rsp();
    check_eq("solo1_rsp_id", rsp_id, 1);
    check_eq("solo1_rsp_data", rsp_data, 12'hFFF);
    step();

`ifdef PAT_SCHED_PERF_EN
    do_reset();
    step();
    check_eq("perf_rst_cnt0", gnt_cnt0, 0);
    check_eq("perf_rst_cnt1", gnt_cnt1, 0);
    txn(1'b0);
    txn(1'b1);
    txn(1'b0);
    txn(1'b1);
    txn(1'b0);
    check_eq("perf_cnt0", gnt_cnt0, 3);
    check_eq("perf_cnt1", gnt_cnt1, 2);
    force dut.gnt_cnt0 = 16'hFFFF;
    step();
    release dut.gnt_cnt0;
    txn(1'b0);
    check_eq("perf_wrap", gnt_cnt0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
